// File: rtl/bus_tstate_ctrl.sv
// Machine-cycle timing generator for the 8085 core.
// Takes machine-cycle requests from the instruction sequencer and steps through T1..T6/TWAIT.
// Also handles HOLD and HALT, and drives ALE, the bus strobes, the status lines and HLDA.
// Every output is decoded from registered state only.
module bus_tstate_ctrl #(
    parameter int MAX_WAIT = 0
) (
    input  logic       phi1,
    input  logic       reset,
    input  logic       mc_valid,
    output logic       mc_ready,
    input  logic [2:0] mc_type,
    input  logic [2:0] mc_len,
    input  logic       ready,
    input  logic       hold,
    input  logic       intr_pend,
    output logic [3:0] tstate,
    output logic       ale,
    output logic       rd_n,
    output logic       wr_n,
    output logic       inta_n,
    output logic       s1,
    output logic       s0,
    output logic       io_m,
    output logic       hlda,
    output logic       bus_float,
    output logic       cycle_done,
    output logic       wait_timeout
);

    typedef enum logic [3:0] {
        TRST  = 4'd0,
        T1    = 4'd1,
        T2    = 4'd2,
        T3    = 4'd3,
        T4    = 4'd4,
        T5    = 4'd5,
        T6    = 4'd6,
        TWAIT = 4'd7,
        THOLD = 4'd8,
        THALT = 4'd9,
        TIDLE = 4'd10
    } tstate_t;

    localparam logic [2:0] MC_OF   = 3'd0;
    localparam logic [2:0] MC_MR   = 3'd1;
    localparam logic [2:0] MC_MW   = 3'd2;
    localparam logic [2:0] MC_IOR  = 3'd3;
    localparam logic [2:0] MC_IOW  = 3'd4;
    localparam logic [2:0] MC_INTA = 3'd5;
    localparam logic [2:0] MC_BI   = 3'd6;
    localparam logic [2:0] MC_HALT = 3'd7;

    // The wait counter saturates, so an unlimited wait can never wrap into a false timeout.
    localparam logic [15:0] MAX_W = 16'(MAX_WAIT);

    tstate_t     r_state_reg, w_state_next;
    logic [2:0]  r_type_reg, w_type_next;
    logic [2:0]  r_len_reg, w_len_next;
    logic [15:0] r_wait_cnt_reg, w_wait_cnt_next;
    logic        r_from_halt_reg, w_from_halt_next;
    logic        r_timeout_reg, w_timeout_next;

    logic        w_last;
    logic        w_cyc_ok;
    logic        w_strobe_phase;
    logic [2:0]  w_eff_len;

    // The last T-state is the one whose number matches the latched length.
    assign w_last = ((r_state_reg == T3) && (r_len_reg == 3'd3)) ||
                    ((r_state_reg == T4) && (r_len_reg == 3'd4)) ||
                    ((r_state_reg == T5) && (r_len_reg == 3'd5)) ||
                    ((r_state_reg == T6) && (r_len_reg == 3'd6));
    assign w_cyc_ok = (r_type_reg != MC_HALT);

    // Only fetch and interrupt-acknowledge cycles may stretch to T4..T6.
    // An out-of-range length falls back to 4.
    always_comb begin
        w_eff_len = 3'd3;
        if (mc_type == MC_OF || mc_type == MC_INTA) begin
            if (mc_len >= 3'd4 && mc_len <= 3'd6) begin
                w_eff_len = mc_len;
            end else begin
                w_eff_len = 3'd4;
            end
        end
    end

    // State and latched cycle attributes.
    always_ff @(posedge phi1) begin
        if (reset) begin
            r_state_reg     <= TRST;
            r_type_reg      <= MC_OF;
            r_len_reg       <= 3'd3;
            r_wait_cnt_reg  <= 16'd0;
            r_from_halt_reg <= 1'b0;
            r_timeout_reg   <= 1'b0;
        end else begin
            r_state_reg     <= w_state_next;
            r_type_reg      <= w_type_next;
            r_len_reg       <= w_len_next;
            r_wait_cnt_reg  <= w_wait_cnt_next;
            r_from_halt_reg <= w_from_halt_next;
            r_timeout_reg   <= w_timeout_next;
        end
    end

    // Next-state logic.
    // At a decision point (TIDLE or the last T-state), hold beats a new transfer, which beats going idle.
    always_comb begin
        w_state_next     = r_state_reg;
        w_type_next      = r_type_reg;
        w_len_next       = r_len_reg;
        w_wait_cnt_next  = r_wait_cnt_reg;
        w_from_halt_next = r_from_halt_reg;
        w_timeout_next   = 1'b0;

        if (r_state_reg == TIDLE || (w_last && w_cyc_ok)) begin
            if (hold) begin
                w_state_next     = THOLD;
                w_from_halt_next = 1'b0;
            end else if (mc_valid) begin
                w_state_next    = T1;
                w_type_next     = mc_type;
                w_len_next      = w_eff_len;
                w_wait_cnt_next = 16'd0;
            end else begin
                w_state_next = TIDLE;
            end
        end else begin
            case (r_state_reg)
                TRST: w_state_next = TIDLE;
                T1:   w_state_next = (r_type_reg == MC_HALT) ? THALT : T2;
                T2, TWAIT: begin
                    if (r_type_reg == MC_BI) begin
                        w_state_next = T3;
                    end else if (r_state_reg == TWAIT && MAX_WAIT > 0 &&
                                 r_wait_cnt_reg == MAX_W) begin
                        w_state_next   = T3;
                        w_timeout_next = 1'b1;
                    end else if (ready) begin
                        w_state_next = T3;
                    end else begin
                        w_state_next = TWAIT;
                        if (r_wait_cnt_reg != 16'hFFFF) begin
                            w_wait_cnt_next = r_wait_cnt_reg + 16'd1;
                        end
                    end
                end
                T3:   w_state_next = T4;
                T4:   w_state_next = T5;
                T5:   w_state_next = T6;
                THOLD: begin
                    if (!hold) begin
                        w_state_next = r_from_halt_reg ? THALT : TIDLE;
                    end
                end
                THALT: begin
                    if (hold) begin
                        w_state_next     = THOLD;
                        w_from_halt_next = 1'b1;
                    end else if (intr_pend) begin
                        w_state_next = TIDLE;
                    end
                end
                default: w_state_next = TIDLE;
            endcase
        end
    end

    assign w_strobe_phase = (r_state_reg == T2) || (r_state_reg == TWAIT) ||
                            (r_state_reg == T3);

    // Output decode from the registered state, type and length.
    always_comb begin
        tstate       = r_state_reg;
        mc_ready     = (r_state_reg == TIDLE) || (w_last && w_cyc_ok);
        ale          = (r_state_reg == T1) && (r_type_reg != MC_BI) &&
                       (r_type_reg != MC_HALT);
        rd_n         = 1'b1;
        wr_n         = 1'b1;
        inta_n       = 1'b1;
        s1           = 1'b0;
        s0           = 1'b0;
        io_m         = 1'b0;
        hlda         = (r_state_reg == THOLD);
        bus_float    = (r_state_reg == TRST) || (r_state_reg == THOLD) ||
                       (r_state_reg == THALT);
        cycle_done   = w_last && w_cyc_ok;
        wait_timeout = (r_state_reg == T3) && r_timeout_reg;

        if (w_strobe_phase) begin
            case (r_type_reg)
                MC_OF, MC_MR, MC_IOR: rd_n   = 1'b0;
                MC_MW, MC_IOW:        wr_n   = 1'b0;
                MC_INTA:              inta_n = 1'b0;
                default: ;
            endcase
        end

        // Status is valid from T1 through the last T-state; THOLD/THALT/TIDLE stay at zero.
        if (r_state_reg >= T1 && r_state_reg <= TWAIT) begin
            case (r_type_reg)
                MC_OF:   {s1, s0, io_m} = 3'b110;
                MC_MR:   {s1, s0, io_m} = 3'b100;
                MC_MW:   {s1, s0, io_m} = 3'b010;
                MC_IOR:  {s1, s0, io_m} = 3'b101;
                MC_IOW:  {s1, s0, io_m} = 3'b011;
                MC_INTA: {s1, s0, io_m} = 3'b111;
                MC_BI:   {s1, s0, io_m} = 3'b100;
                default: {s1, s0, io_m} = 3'b000;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_tstate_ctrl.sv
// Randomised scoreboard bench for bus_tstate_ctrl.
// Two instances run side by side: MAX_WAIT=0 (unlimited) and MAX_WAIT=2.
// A cycle-level reference model predicts each instance's output word after every edge.
// A monitor compares the prediction against the instance half a period later.
module tb_bus_tstate_ctrl;

    localparam int NCYC = 4000;

    logic       phi1 = 1'b0;
    logic       reset = 1'b1;
    logic       mc_valid = 1'b0;
    logic [2:0] mc_type = 3'd0;
    logic [2:0] mc_len = 3'd0;
    logic       ready = 1'b1;
    logic       hold = 1'b0;
    logic       intr_pend = 1'b0;

    always #5 phi1 = ~phi1;

    // Outputs of both instances, packed for comparison.
    logic [3:0] tst0, tst1;
    logic rdy0, ale0, rd0, wr0, ia0, s1_0, s0_0, iom0, hl0, bf0, cd0, to0;
    logic rdy1, ale1, rd1, wr1, ia1, s1_1, s0_1, iom1, hl1, bf1, cd1, to1;
    logic [15:0] act0, act1;
    assign act0 = {tst0, rdy0, ale0, rd0, wr0, ia0, s1_0, s0_0, iom0, hl0, bf0, cd0, to0};
    assign act1 = {tst1, rdy1, ale1, rd1, wr1, ia1, s1_1, s0_1, iom1, hl1, bf1, cd1, to1};

    bus_tstate_ctrl #(.MAX_WAIT(0)) u_dut0 (
        .phi1(phi1), .reset(reset), .mc_valid(mc_valid), .mc_ready(rdy0),
        .mc_type(mc_type), .mc_len(mc_len), .ready(ready), .hold(hold),
        .intr_pend(intr_pend), .tstate(tst0), .ale(ale0), .rd_n(rd0), .wr_n(wr0),
        .inta_n(ia0), .s1(s1_0), .s0(s0_0), .io_m(iom0), .hlda(hl0),
        .bus_float(bf0), .cycle_done(cd0), .wait_timeout(to0)
    );

    bus_tstate_ctrl #(.MAX_WAIT(2)) u_dut1 (
        .phi1(phi1), .reset(reset), .mc_valid(mc_valid), .mc_ready(rdy1),
        .mc_type(mc_type), .mc_len(mc_len), .ready(ready), .hold(hold),
        .intr_pend(intr_pend), .tstate(tst1), .ale(ale1), .rd_n(rd1), .wr_n(wr1),
        .inta_n(ia1), .s1(s1_1), .s0(s0_1), .io_m(iom1), .hlda(hl1),
        .bus_float(bf1), .cycle_done(cd1), .wait_timeout(to1)
    );

    // Reference model state, one slot per instance.
    // State numbers are the tstate encoding: 0 TRST, 1..6 T1..T6, 7 TWAIT, 8 THOLD, 9 THALT, 10 TIDLE.
    int m_st   [2];
    int m_type [2];
    int m_len  [2];
    int m_cnt  [2];
    int m_to   [2];
    int m_fh   [2];
    int maxw   [2];

    logic [2:0] stat_tbl [8];

    logic [15:0] exp_q0 [$];
    logic [15:0] exp_q1 [$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_xfer   = 0;

    // Expected output word for a model state.
    function automatic logic [15:0] exp_vec(int st, int typ, int len, int to);
        logic last, rdyo, aleo, ph, rdo, wro, iao, hlo, bfo, cdo, tof;
        logic [2:0] stat;
        last = (st >= 3) && (st <= 6) && (st == len);
        rdyo = (st == 10) || (last && typ != 7);
        aleo = (st == 1) && (typ != 6) && (typ != 7);
        ph   = (st == 2) || (st == 7) || (st == 3);
        rdo  = !(ph && (typ == 0 || typ == 1 || typ == 3));
        wro  = !(ph && (typ == 2 || typ == 4));
        iao  = !(ph && typ == 5);
        stat = (st >= 1 && st <= 7) ? stat_tbl[typ] : 3'b000;
        hlo  = (st == 8);
        bfo  = (st == 0) || (st == 8) || (st == 9);
        cdo  = last && (typ != 7);
        tof  = (st == 3) && (to != 0);
        return {4'(st), rdyo, aleo, rdo, wro, iao, stat, hlo, bfo, cdo, tof};
    endfunction

    // Advance model k by one edge using the currently driven inputs.
    task automatic model_step(input int k);
        int  st;
        bit  last;
        st = m_st[k];
        last = (st >= 3) && (st <= 6) && (st == m_len[k]);
        m_to[k] = 0;
        if (reset) begin
            m_st[k] = 0; m_cnt[k] = 0; m_fh[k] = 0; m_type[k] = 0; m_len[k] = 3;
        end else if (st == 10 || (last && m_type[k] != 7)) begin
            if (hold) begin
                m_st[k] = 8; m_fh[k] = 0;
            end else if (mc_valid) begin
                m_st[k]   = 1;
                m_type[k] = int'(mc_type);
                m_cnt[k]  = 0;
                if (mc_type == 3'd0 || mc_type == 3'd5)
                    m_len[k] = (mc_len >= 3'd4 && mc_len <= 3'd6) ? int'(mc_len) : 4;
                else
                    m_len[k] = 3;
                if (k == 0) begin
                    n_xfer++;
                    $display("xfer %0d cycle %0d type %0d len %0d", n_xfer, cyc,
                             m_type[k], m_len[k]);
                end
            end else begin
                m_st[k] = 10;
            end
        end else if (st == 0) begin
            m_st[k] = 10;
        end else if (st == 1) begin
            m_st[k] = (m_type[k] == 7) ? 9 : 2;
        end else if (st == 2 || st == 7) begin
            if (m_type[k] == 6) m_st[k] = 3;
            else if (st == 7 && maxw[k] > 0 && m_cnt[k] == maxw[k]) begin
                m_st[k] = 3; m_to[k] = 1;
            end else if (ready) m_st[k] = 3;
            else begin
                m_st[k] = 7; m_cnt[k]++;
            end
        end else if (st >= 3 && st <= 5) begin
            m_st[k] = st + 1;
        end else if (st == 8) begin
            if (!hold) m_st[k] = (m_fh[k] != 0) ? 9 : 10;
        end else if (st == 9) begin
            if (hold) begin
                m_st[k] = 8; m_fh[k] = 1;
            end else if (intr_pend) m_st[k] = 10;
        end
    endtask

    task automatic predict();
        model_step(0);
        model_step(1);
        exp_q0.push_back(exp_vec(m_st[0], m_type[0], m_len[0], m_to[0]));
        exp_q1.push_back(exp_vec(m_st[1], m_type[1], m_len[1], m_to[1]));
    endtask

    // Monitor: after each edge pop one prediction per instance and compare.
    always @(posedge phi1) begin
        logic [15:0] e0, e1;
        #1;
        n_checks += 2;
        if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty cycle %0d: got no prediction, required one", cyc);
        end else begin
            e0 = exp_q0.pop_front();
            e1 = exp_q1.pop_front();
            if (act0 !== e0) begin
                n_fail++;
                $display("FAIL outputs_maxwait0 cycle %0d: got %h required %h", cyc, act0, e0);
            end
            if (act1 !== e1) begin
                n_fail++;
                $display("FAIL outputs_maxwait2 cycle %0d: got %h required %h", cyc, act1, e1);
            end
        end
    end

    // Randomised stimulus with sticky hold/reset and bursts of ready=0 to reach long waits.
    initial begin
        int rst_cnt, hold_cnt, wait_cnt;
        stat_tbl[0] = 3'b110; stat_tbl[1] = 3'b100; stat_tbl[2] = 3'b010;
        stat_tbl[3] = 3'b101; stat_tbl[4] = 3'b011; stat_tbl[5] = 3'b111;
        stat_tbl[6] = 3'b100; stat_tbl[7] = 3'b000;
        maxw[0] = 0; maxw[1] = 2;
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_type[k] = 0; m_len[k] = 3; m_cnt[k] = 0; m_to[k] = 0; m_fh[k] = 0;
        end
        rst_cnt = 1; hold_cnt = 0; wait_cnt = 0;
        reset = 1'b1;
        predict();
        for (int c = 1; c < NCYC; c++) begin
            @(negedge phi1);
            cyc = c;
            if (rst_cnt > 0) begin
                reset = 1'b1; rst_cnt--;
            end else begin
                reset = 1'b0;
                if ($urandom_range(0, 199) == 0) rst_cnt = int'($urandom_range(1, 2));
            end
            if (hold_cnt > 0) begin
                hold = 1'b1; hold_cnt--;
            end else begin
                hold = 1'b0;
                if ($urandom_range(0, 19) == 0) hold_cnt = int'($urandom_range(1, 5));
            end
            if (wait_cnt > 0) begin
                ready = 1'b0; wait_cnt--;
            end else begin
                ready = 1'b1;
                if ($urandom_range(0, 3) == 0) wait_cnt = int'($urandom_range(1, 4));
            end
            mc_valid  = ($urandom_range(0, 3) != 0);
            mc_type   = 3'($urandom_range(0, 7));
            mc_len    = 3'($urandom_range(0, 7));
            intr_pend = ($urandom_range(0, 7) == 0);
            predict();
        end
        @(posedge phi1);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
